halo_tile_buffer: RTL and testbench

Banked tile store that answers the pooling filter's read requests. Upstream halo logic streams one 32-lane row per beat into BANKS x DEPTH memory. The block then announces a complete tile and serves per-bank reads with fixed 1-cycle latency until the consumer signals done. It sits between halo generation and the pooling filter, owning the far end of its rd_addr/rd_en/data_in/valid_in/valid_out interface.

---
 rtl/halo_tile_buffer.sv | 126 ++++++++++++
 tb/tb_halo_tile_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/halo_tile_buffer.sv
// rtl/halo_tile_buffer.sv - banked tile store: fills one row per beat, then serves per-bank reads
// with 1-cycle latency until the consumer signals done.
module halo_tile_buffer #(
  parameter int BANKS  = 32,
  parameter int DEPTH  = 32,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                               clk,
  input  logic                               res,
  input  logic [BANKS-1:0][DATA_W-1:0]       wr_data,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [ADDR_W:0]                    tile_rows,
  input  logic [BANKS-1:0][ADDR_W-1:0]       rd_addr,
  input  logic [BANKS-1:0]                   rd_en,
  output logic [BANKS-1:0][DATA_W-1:0]       rd_data,
  output logic                               tile_valid,
  input  logic                               tile_done,
  output logic                               rd_err,
  output logic [ADDR_W:0]                    row_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILL    = 2'd1;
  localparam logic [1:0] ST_SERVE   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [1:0]                     state_q, state_d;
  logic [ADDR_W:0]                size_q, size_d;
  logic [ADDR_W:0]                row_q, row_d;
  logic                           err_q, err_d;
  logic [BANKS-1:0]               bad_rd;
  logic [BANKS-1:0][DATA_W-1:0]   rd_data_q;
  logic                           accept;

  logic [DATA_W-1:0] mem_q [BANKS][DEPTH];

  assign accept     = (state_q == ST_FILL) && wr_valid;
  assign wr_ready   = (state_q == ST_FILL);
  assign tile_valid = (state_q == ST_SERVE);
  assign rd_data    = rd_data_q;
  assign rd_err     = err_q;
  assign row_count  = row_q;

  // A read is illegal outside SERVE, or beyond the rows actually filled in this tile.
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      bad_rd[b] = rd_en[b] && ((state_q != ST_SERVE) || ({1'b0, rd_addr[b]} >= size_q));
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    row_d   = row_q;
    err_d   = err_q | (|bad_rd);
    case (state_q)
      ST_IDLE: begin
        if (tile_rows == '0) begin
          size_d = ONE_C;
        end else if (tile_rows > DEPTH_C) begin
          size_d = DEPTH_C;
        end else begin
          size_d = tile_rows;
        end
        row_d   = '0;
        state_d = ST_FILL;
      end
      ST_FILL: begin
        if (wr_valid) begin
          row_d = row_q + ONE_C;
          if (row_d == size_q) begin
            state_d = ST_SERVE;
          end
        end
      end
      ST_SERVE: begin
        if (tile_done) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

  // Storage is never reset; fill and serve are exclusive so there is no collision.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int b = 0; b < BANKS; b++) begin
        mem_q[b][row_q[ADDR_W-1:0]] <= wr_data[b];
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rd_data_q <= '0;
    end else if (state_q == ST_SERVE) begin
      for (int b = 0; b < BANKS; b++) begin
        if (rd_en[b]) begin
          rd_data_q[b] <= bad_rd[b] ? '0 : mem_q[b][rd_addr[b]];
        end
      end
    end
  end

endmodule

// File: tb/tb_halo_tile_buffer.sv
// tb/tb_halo_tile_buffer.sv - scoreboard bench for halo_tile_buffer fill/serve/release behaviour.
module tb_halo_tile_buffer;

  localparam int BANKS  = 32;
  localparam int DEPTH  = 32;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  logic                           clk = 1'b0;
  logic                           res = 1'b0;
  logic [BANKS-1:0][DATA_W-1:0]   wr_data = '0;
  logic                           wr_valid = 1'b0;
  logic                           wr_ready;
  logic [ADDR_W:0]                tile_rows = '0;
  logic [BANKS-1:0][ADDR_W-1:0]   rd_addr = '0;
  logic [BANKS-1:0]               rd_en = '0;
  logic [BANKS-1:0][DATA_W-1:0]   rd_data;
  logic                           tile_valid;
  logic                           tile_done = 1'b0;
  logic                           rd_err;
  logic [ADDR_W:0]                row_count;

  halo_tile_buffer #(.BANKS(BANKS), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .res(res), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .tile_rows(tile_rows), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .tile_valid(tile_valid), .tile_done(tile_done), .rd_err(rd_err), .row_count(row_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bank;
    logic [15:0] val;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] model [BANKS][DEPTH];
  int          msize = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_rows(input int t);
    if (t == 0) return 1;
    if (t > DEPTH) return DEPTH;
    return t;
  endfunction

  function automatic logic [15:0] word(input int r, input int b, input int seed);
    return {8'(r + seed), 8'(b)};
  endfunction

  // Drives beats from row 'start' until row n-1 is accepted; ends on a negedge.
  task automatic fill(input int start, input int n, input int seed);
    int r = start;
    int guard = 0;
    while (r < n && guard < 100) begin
      for (int b = 0; b < BANKS; b++) wr_data[b] = word(r, b, seed);
      wr_valid = 1'b1;
      if (wr_ready) begin
        for (int b = 0; b < BANKS; b++) model[b][r] = wr_data[b];
        r++;
      end
      @(negedge clk);
      guard++;
    end
    wr_valid = 1'b0;
    if (r < n) check("fill_timeout", 32'(r), 32'(n));
  endtask

  task automatic rd_cycle(input logic [BANKS-1:0] en, input logic [BANKS-1:0][ADDR_W-1:0] a,
                          input logic done);
    exp_t e;
    for (int b = 0; b < BANKS; b++) begin
      if (en[b]) begin
        e.bank = b;
        e.val  = (int'(a[b]) >= msize) ? 16'h0 : model[b][a[b]];
        sbq.push_back(e);
      end
    end
    rd_en = en;
    rd_addr = a;
    tile_done = done;
    @(negedge clk);
    rd_en = '0;
    tile_done = 1'b0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check($sformatf("rd_data[%0d]", e.bank), 32'(rd_data[e.bank]), 32'(e.val));
    end
  endtask

  task automatic rd_one(input int b, input int addr, input logic done);
    logic [BANKS-1:0]             en;
    logic [BANKS-1:0][ADDR_W-1:0] a;
    en = '0;
    a = '0;
    en[b] = 1'b1;
    a[b] = ADDR_W'(addr);
    rd_cycle(en, a, done);
  endtask

  // Ends the tile; rd_bank >= 0 issues a bank read (row 1) in the same cycle as tile_done.
  task automatic finish_tile(input int next_rows, input int rd_bank);
    tile_rows = (ADDR_W+1)'(next_rows);
    if (rd_bank >= 0) begin
      rd_one(rd_bank, 1, 1'b1);
    end else begin
      tile_done = 1'b1;
      @(negedge clk);
      tile_done = 1'b0;
    end
    check("release tile_valid", 32'(tile_valid), 32'd0);
    check("release wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    check("idle wr_ready", 32'(wr_ready), 32'd0);
    msize = clamp_rows(next_rows);
    @(negedge clk);
    check("first fill wr_ready", 32'(wr_ready), 32'd1);
    check("fill row_count cleared", 32'(row_count), 32'd0);
  endtask

  initial begin
    logic [BANKS-1:0]             en;
    logic [BANKS-1:0][ADDR_W-1:0] a;
    logic [3:0]                   vpat;
    int                           r;

    tile_rows = 6'd8;
    repeat (2) @(negedge clk);
    check("reset wr_ready", 32'(wr_ready), 32'd0);
    check("reset tile_valid", 32'(tile_valid), 32'd0);
    check("reset row_count", 32'(row_count), 32'd0);
    check("reset rd_err", 32'(rd_err), 32'd0);
    check("reset rd_data0", 32'(rd_data[0]), 32'd0);
    res = 1'b1;
    msize = 8;

    // Abort mid-fill with an asynchronous reset.
    fill(0, 5, 8'h50);
    check("midfill row_count", 32'(row_count), 32'd5);
    check("midfill wr_ready", 32'(wr_ready), 32'd1);
    #2 res = 1'b0;
    #1;
    check("async wr_ready", 32'(wr_ready), 32'd0);
    check("async row_count", 32'(row_count), 32'd0);
    check("async tile_valid", 32'(tile_valid), 32'd0);
    @(negedge clk);
    tile_rows = 6'd4;
    msize = 4;
    res = 1'b1;
    fill(0, 4, 8'h10);
    check("t1 tile_valid", 32'(tile_valid), 32'd1);
    check("t1 row_count", 32'(row_count), 32'd4);
    rd_one(9, 3, 1'b0);
    rd_one(0, 0, 1'b0);
    check("t1 rd_err", 32'(rd_err), 32'd0);

    // Backpressure: wr_valid 1,0,0,1 writes two rows.
    finish_tile(3, -1);
    vpat = 4'b1001;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = vpat[3-i];
      for (int b = 0; b < BANKS; b++) wr_data[b] = word(r, b, 8'h30);
      if (wr_valid) begin
        for (int b = 0; b < BANKS; b++) model[b][r] = wr_data[b];
        r++;
      end
      @(negedge clk);
      check($sformatf("stall row_count %0d", i), 32'(row_count), 32'(r));
      check($sformatf("stall wr_ready %0d", i), 32'(wr_ready), 32'd1);
    end
    wr_valid = 1'b0;
    fill(2, 3, 8'h30);
    check("t3 tile_valid", 32'(tile_valid), 32'd1);
    rd_one(1, 2, 1'b0);

    // Basic 7-row tile, read all banks at b%7.
    finish_tile(7, -1);
    fill(0, 6, 0);
    check("t2 pre tile_valid", 32'(tile_valid), 32'd0);
    fill(6, 7, 0);
    check("t2 tile_valid", 32'(tile_valid), 32'd1);
    check("t2 wr_ready", 32'(wr_ready), 32'd0);
    check("t2 row_count", 32'(row_count), 32'd7);
    en = '1;
    for (int b = 0; b < BANKS; b++) a[b] = ADDR_W'(b % 7);
    rd_cycle(en, a, 1'b0);
    check("t2 spec word b9", 32'(rd_data[9]), 32'h0209);
    @(negedge clk);
    check("t2 hold rd_data5", 32'(rd_data[5]), 32'h0505);
    check("t2 wr_ready serve", 32'(wr_ready), 32'd0);

    // Done together with a read of bank 0 row 1.
    finish_tile(4, 0);

    // Out-of-range read.
    fill(0, 4, 0);
    rd_one(0, 5, 1'b0);
    check("t4 rd_err", 32'(rd_err), 32'd1);
    rd_one(0, 2, 1'b0);
    check("t4 row2 word", 32'(rd_data[0]), 32'h0200);
    finish_tile(32, -1);
    check("t4 rd_err sticky", 32'(rd_err), 32'd1);

    // Full-depth tile, then tile_rows=0 behaving as 1.
    fill(0, 32, 8'h20);
    check("t6 row_count 32", 32'(row_count), 32'd32);
    check("t6 tile_valid", 32'(tile_valid), 32'd1);
    rd_one(5, 31, 1'b0);
    rd_one(31, 31, 1'b0);
    rd_one(0, 0, 1'b0);
    finish_tile(0, -1);
    fill(0, 1, 8'h60);
    check("t6 single tile_valid", 32'(tile_valid), 32'd1);
    check("t6 single row_count", 32'(row_count), 32'd1);
    rd_one(2, 0, 1'b0);
    rd_one(3, 1, 1'b0);

    // rd_err clears only by reset; a read outside SERVE sets it and leaves rd_data alone.
    res = 1'b0;
    #1;
    check("final reset rd_err", 32'(rd_err), 32'd0);
    @(negedge clk);
    tile_rows = 6'd2;
    res = 1'b1;
    rd_en = '0;
    rd_en[0] = 1'b1;
    rd_addr = '0;
    @(negedge clk);
    rd_en = '0;
    check("idle read rd_err", 32'(rd_err), 32'd1);
    check("idle read rd_data0", 32'(rd_data[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
